// File: rtl/stack_upstream_collector.sv
// ---------------------------------------------------------------------------
// stack_upstream_collector
//   Stack-side receiver for the PE upstream interface. NUM_PE PE ports are
//   arbitrated round-robin at packet granularity, so packets never interleave.
//   Accepted beats are buffered in a small FIFO that drives the single stack
//   upstream bus toward the stack/manager.
//
// Ports
//   clk, reset_poweron            clock, async active-high reset
//   pe__stu__valid/cntl/type/
//     data/oob_data               per-PE beat, PE i at [i*W +: W]
//   stu__pe__ready                per-PE ready (one-hot or zero, combinational)
//   stu__sys__valid/cntl/type/
//     data/oob_data/src_pe        output beat taken from the FIFO head
//   sys__stu__ready               downstream ready
//   stu__sys__proto_err           sticky protocol error
//
// Build option
//   STU_PROTOCOL_CHECK_EN : when defined, dropped stray beats and packet
//   restarts set stu__sys__proto_err; otherwise it is tied 0.
// ---------------------------------------------------------------------------
module stack_upstream_collector #(
    parameter int unsigned NUM_PE     = 4,
    parameter int unsigned CNTL_W     = 2,
    parameter int unsigned TYPE_W     = 2,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned OOB_W      = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    localparam int unsigned PE_W      = $clog2(NUM_PE)
) (
    input  logic                       clk,
    input  logic                       reset_poweron,
    input  logic [NUM_PE-1:0]          pe__stu__valid,
    input  logic [NUM_PE*CNTL_W-1:0]   pe__stu__cntl,
    input  logic [NUM_PE*TYPE_W-1:0]   pe__stu__type,
    input  logic [NUM_PE*DATA_W-1:0]   pe__stu__data,
    input  logic [NUM_PE*OOB_W-1:0]    pe__stu__oob_data,
    output logic [NUM_PE-1:0]          stu__pe__ready,
    output logic                       stu__sys__valid,
    output logic [CNTL_W-1:0]          stu__sys__cntl,
    output logic [TYPE_W-1:0]          stu__sys__type,
    output logic [DATA_W-1:0]          stu__sys__data,
    output logic [OOB_W-1:0]           stu__sys__oob_data,
    output logic [PE_W-1:0]            stu__sys__src_pe,
    input  logic                       sys__stu__ready,
    output logic                       stu__sys__proto_err
);

    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = CNTL_W + TYPE_W + DATA_W + OOB_W + PE_W;

    localparam logic [CNTL_W-1:0] CNTL_MOM     = CNTL_W'(2'b00);
    localparam logic [CNTL_W-1:0] CNTL_SOM     = CNTL_W'(2'b01);
    localparam logic [CNTL_W-1:0] CNTL_EOM     = CNTL_W'(2'b10);
    localparam logic [CNTL_W-1:0] CNTL_SOM_EOM = CNTL_W'(2'b11);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [PE_W-1:0]     owner_q, owner_d;
    logic [PE_W-1:0]     rr_q, rr_d;
    logic [PE_W-1:0]     grant;
    logic                grant_vld;
    logic [PE_W-1:0]     sel;
    logic [CNTL_W-1:0]   sel_cntl;
    logic                sel_ready;
    logic                accept;
    logic                push;
    logic                pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [ADDR_W:0]     wr_ptr_q, rd_ptr_q;
    logic [ENTRY_W-1:0]  mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  wr_entry;
    logic [ENTRY_W-1:0]  head;

    // (base + k) mod NUM_PE for k in 1..NUM_PE
    function automatic logic [PE_W-1:0] wrap_add(input logic [PE_W-1:0] base,
                                                 input int unsigned k);
        int unsigned s;
        s = 32'(base) + k;
        if (s >= NUM_PE) s = s - NUM_PE;
        return PE_W'(s);
    endfunction

    // Round-robin search starting just after the last packet's PE
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int unsigned k = 1; k <= NUM_PE; k++) begin
            if (!grant_vld && pe__stu__valid[wrap_add(rr_q, k)]) begin
                grant_vld = 1'b1;
                grant     = wrap_add(rr_q, k);
            end
        end
    end

    // While locked the owner is the only candidate
    assign sel      = (state_q == ST_LOCKED) ? owner_q : grant;
    assign sel_cntl = pe__stu__cntl[32'(sel)*CNTL_W +: CNTL_W];
    assign wr_entry = {sel_cntl,
                       pe__stu__type[32'(sel)*TYPE_W +: TYPE_W],
                       pe__stu__data[32'(sel)*DATA_W +: DATA_W],
                       pe__stu__oob_data[32'(sel)*OOB_W +: OOB_W],
                       sel};

    // Ready is gated by reset so nothing is accepted while reset is held
    assign sel_ready = !reset_poweron && !fifo_full &&
                       ((state_q == ST_LOCKED) || grant_vld);
    assign accept    = sel_ready && pe__stu__valid[sel];

    // Next-state, write enable and ready decode
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        rr_d           = rr_q;
        push           = 1'b0;
        stu__pe__ready = '0;
        stu__pe__ready[sel] = sel_ready;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rr_d = grant;
                    if (sel_cntl == CNTL_SOM) begin
                        state_d = ST_LOCKED;
                        owner_d = grant;
                        push    = 1'b1;
                    end else if (sel_cntl == CNTL_SOM_EOM) begin
                        push    = 1'b1;
                    end
                    // stray MOM/EOM: dropped, pointer still advances
                end
            end
            ST_LOCKED: begin
                if (accept) begin
                    push = 1'b1;
                    if (sel_cntl == CNTL_EOM || sel_cntl == CNTL_SOM_EOM) begin
                        state_d = ST_IDLE;
                        rr_d    = owner_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= PE_W'(NUM_PE - 1);
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
        end
    end

    // FIFO pointers carry an extra wrap bit to tell full from empty
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_W{1'b0}}});
    assign pop        = !fifo_empty && sys__stu__ready;

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + (ADDR_W+1)'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    // Storage array, no reset needed: read data is masked while empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_entry;
    end

    assign stu__sys__valid = !fifo_empty;
    assign head = fifo_empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign {stu__sys__cntl, stu__sys__type, stu__sys__data,
            stu__sys__oob_data, stu__sys__src_pe} = head;

`ifdef STU_PROTOCOL_CHECK_EN
    logic err_event;
    logic proto_err_q;

    // Stray MOM/EOM while idle, or a restart from the owner while locked
    always_comb begin
        err_event = 1'b0;
        if (accept) begin
            if (state_q == ST_IDLE)
                err_event = (sel_cntl == CNTL_MOM) || (sel_cntl == CNTL_EOM);
            else
                err_event = (sel_cntl == CNTL_SOM) || (sel_cntl == CNTL_SOM_EOM);
        end
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) proto_err_q <= 1'b0;
        else if (err_event) proto_err_q <= 1'b1;
    end

    assign stu__sys__proto_err = proto_err_q;
`else
    assign stu__sys__proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_stack_upstream_collector.sv
// ---------------------------------------------------------------------------
// tb_stack_upstream_collector
//   Self-checking bench: a per-cycle vector table, hand-written sequences for
//   back-pressure, stray beats and mid-stream reset, then randomized packet
//   traffic checked against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_stack_upstream_collector;

    localparam int unsigned NUM_PE = 4;
    localparam int unsigned DEPTH  = 4;

`ifdef STU_PROTOCOL_CHECK_EN
    localparam bit PERR_EN = 1'b1;
`else
    localparam bit PERR_EN = 1'b0;
`endif

    localparam logic [1:0] MOM = 2'b00, SOM = 2'b01, EOM = 2'b10, SEOM = 2'b11;

    typedef struct packed {
        logic [1:0]  cntl;
        logic [1:0]  typ;
        logic [63:0] data;
        logic [31:0] oob;
        logic [1:0]  src;
    } beat_t;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [7:0] cntl;
        logic       sys_rdy;
        logic [3:0] exp_ready;
        logic       exp_vld;
        logic [1:0] exp_cntl;
        logic [1:0] exp_src;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   pe_valid;
    logic [7:0]   pe_cntl;
    logic [7:0]   pe_type;
    logic [255:0] pe_data;
    logic [127:0] pe_oob;
    logic [3:0]   pe_ready;
    logic         o_valid;
    logic [1:0]   o_cntl;
    logic [1:0]   o_type;
    logic [63:0]  o_data;
    logic [31:0]  o_oob;
    logic [1:0]   o_src;
    logic         sys_rdy;
    logic         perr;
    beat_t        out_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign out_b = {o_cntl, o_type, o_data, o_oob, o_src};

    stack_upstream_collector dut (
        .clk                 (clk),
        .reset_poweron       (rst),
        .pe__stu__valid      (pe_valid),
        .pe__stu__cntl       (pe_cntl),
        .pe__stu__type       (pe_type),
        .pe__stu__data       (pe_data),
        .pe__stu__oob_data   (pe_oob),
        .stu__pe__ready      (pe_ready),
        .stu__sys__valid     (o_valid),
        .stu__sys__cntl      (o_cntl),
        .stu__sys__type      (o_type),
        .stu__sys__data      (o_data),
        .stu__sys__oob_data  (o_oob),
        .stu__sys__src_pe    (o_src),
        .sys__stu__ready     (sys_rdy),
        .stu__sys__proto_err (perr)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        pe_valid = '0;
        sys_rdy  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_one(input int pe, input logic v, input logic [1:0] c, input logic [63:0] d);
        pe_valid              = '0;
        pe_valid[pe]          = v;
        pe_cntl[pe*2 +: 2]    = c;
        pe_data[pe*64 +: 64]  = d;
    endtask

    vec_t       vecs [13];
    logic [1:0] seq6 [6];

    // reference model state
    beat_t      exp_q [$];
    bit         m_locked;
    int         m_owner;
    int         m_last;
    bit         m_err;
    beat_t      src_mem [NUM_PE][64];
    int         src_len [NUM_PE];
    int         src_pos [NUM_PE];

    initial begin
        int         b;
        int         got;
        logic       rdy;
        int         g;
        int         cand;
        logic [3:0] exp_rdy;
        bit         do_pop;
        bit         acc;
        beat_t      nb;
        int         pending;
        int         n;
        int         len;
        int         r;
        logic [1:0] c;

        rst      = 1'b1;
        pe_valid = '0;
        pe_cntl  = '0;
        pe_type  = '0;
        pe_data  = '0;
        pe_oob   = '0;
        sys_rdy  = 1'b0;

        // rst, valid, cntl, sys_rdy | exp_ready, exp_vld, exp_cntl, exp_src
        vecs[0]  = '{1'b0, 4'b0100, 8'h10, 1'b1, 4'b0100, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 4'b0100, 8'h00, 1'b1, 4'b0100, 1'b1, SOM,  2'd2};
        vecs[2]  = '{1'b0, 4'b0100, 8'h20, 1'b1, 4'b0100, 1'b1, MOM,  2'd2};
        vecs[3]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, EOM,  2'd2};
        vecs[4]  = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[5]  = '{1'b1, 4'b1111, 8'hFF, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};
        vecs[6]  = '{1'b0, 4'b1111, 8'hFF, 1'b1, 4'b0001, 1'b0, 2'd0, 2'd0};
        vecs[7]  = '{1'b0, 4'b1111, 8'hFF, 1'b1, 4'b0010, 1'b1, SEOM, 2'd0};
        vecs[8]  = '{1'b0, 4'b1111, 8'hFF, 1'b1, 4'b0100, 1'b1, SEOM, 2'd1};
        vecs[9]  = '{1'b0, 4'b1111, 8'hFF, 1'b1, 4'b1000, 1'b1, SEOM, 2'd2};
        vecs[10] = '{1'b0, 4'b1111, 8'hFF, 1'b1, 4'b0001, 1'b1, SEOM, 2'd3};
        vecs[11] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b1, SEOM, 2'd0};
        vecs[12] = '{1'b0, 4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 2'd0, 2'd0};

        seq6[0] = SOM; seq6[1] = MOM; seq6[2] = MOM;
        seq6[3] = MOM; seq6[4] = MOM; seq6[5] = EOM;

        // reset state, with a PE already asserting valid
        pe_valid = 4'b0001;
        pe_cntl  = 8'h03;
        @(negedge clk);
        check("rst_ready", 128'(pe_ready), 128'(0));
        check("rst_valid", 128'(o_valid), 128'(0));
        check("rst_beat",  128'(out_b), 128'(0));
        check("rst_perr",  128'(perr), 128'(0));
        reset_dut();

        // vector table: single packet from PE2, then reset and SOM_EOM rotation
        for (int i = 0; i < 13; i++) begin
            rst      = vecs[i].rst;
            pe_valid = vecs[i].valid;
            pe_cntl  = vecs[i].cntl;
            sys_rdy  = vecs[i].sys_rdy;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 128'(pe_ready), 128'(vecs[i].exp_ready));
            check($sformatf("vec%0d_valid", i), 128'(o_valid), 128'(vecs[i].exp_vld));
            if (vecs[i].exp_vld)
                check($sformatf("vec%0d_cntl_src", i), 128'({o_cntl, o_src}),
                      128'({vecs[i].exp_cntl, vecs[i].exp_src}));
            @(posedge clk);
            #1;
        end

        // back-pressure: 6-beat packet from PE1 with sys ready low for 10 cycles
        reset_dut();
        pe_cntl = '0;
        b = 0;
        sys_rdy = 1'b0;
        for (int cy = 0; cy < 10; cy++) begin
            drive_one(1, b < 6, seq6[b < 6 ? b : 5], 64'(b));
            @(negedge clk);
            rdy = pe_ready[1] & pe_valid[1];
            if (cy >= 1)
                check("bp_hold", 128'({o_valid, o_cntl, o_src, o_data}),
                      128'({1'b1, SOM, 2'd1, 64'd0}));
            if (cy == 9)
                check("bp_ready_low", 128'(pe_ready), 128'(0));
            @(posedge clk);
            if (rdy) b++;
            #1;
        end
        check("bp_buffered", 128'(b), 128'(4));
        got = 0;
        for (int cy = 0; cy < 30 && got < 6; cy++) begin
            drive_one(1, b < 6, seq6[b < 6 ? b : 5], 64'(b));
            sys_rdy = 1'b1;
            @(negedge clk);
            if (cy == 0)
                check("full_pop_blocks", 128'(pe_ready), 128'(0));
            rdy = pe_ready[1] & pe_valid[1];
            if (o_valid) begin
                check("bp_beat", 128'({o_cntl, o_src, o_data}),
                      128'({seq6[got], 2'd1, 64'(got)}));
                got++;
            end
            @(posedge clk);
            if (rdy) b++;
            #1;
        end
        check("bp_count", 128'(got), 128'(6));

        // stray MOM from PE3 while idle: accepted, dropped, flagged
        reset_dut();
        sys_rdy = 1'b1;
        drive_one(3, 1'b1, MOM, 64'h55);
        @(negedge clk);
        check("stray_ready", 128'(pe_ready), 128'(4'b1000));
        @(posedge clk);
        #1;
        pe_valid = '0;
        @(negedge clk);
        check("stray_no_out", 128'(o_valid), 128'(0));
        check("stray_perr", 128'(perr), 128'(PERR_EN));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stray_no_out2", 128'(o_valid), 128'(0));

        // reset asserted while the FIFO holds 3 beats of a partial packet
        reset_dut();
        sys_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive_one(0, 1'b1, seq6[k], 64'(k + 100));
            @(negedge clk);
            check("pre_rst_ready", 128'(pe_ready), 128'(4'b0001));
            @(posedge clk);
            #1;
        end
        pe_valid = '0;
        @(negedge clk);
        check("pre_rst_valid", 128'(o_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 128'(o_valid), 128'(0));
        check("mid_rst_perr", 128'(perr), 128'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        sys_rdy = 1'b1;
        drive_one(1, 1'b1, SEOM, 64'hABCD);
        @(negedge clk);
        check("post_rst_ready", 128'(pe_ready), 128'(4'b0010));
        @(posedge clk);
        #1;
        pe_valid = '0;
        @(negedge clk);
        check("post_rst_beat", 128'({o_valid, o_cntl, o_src, o_data}),
              128'({1'b1, SEOM, 2'd1, 64'hABCD}));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_empty", 128'(o_valid), 128'(0));
        @(posedge clk);
        #1;

        // randomized packet traffic against the reference model
        for (int i = 0; i < NUM_PE; i++) begin
            n = 0;
            while (n < 40) begin
                r = int'($urandom % 10);
                if (r == 0) begin
                    c = ($urandom % 2) ? MOM : EOM;
                    src_mem[i][n] = {c, 2'($urandom), {$urandom, $urandom}, 32'($urandom), 2'(i)};
                    n++;
                end else begin
                    len = 1 + int'($urandom % 4);
                    for (int j = 0; j < len; j++) begin
                        if (len == 1)          c = SEOM;
                        else if (j == 0)       c = SOM;
                        else if (j == len - 1) c = EOM;
                        else                   c = (r == 1) ? SOM : MOM;
                        src_mem[i][n] = {c, 2'($urandom), {$urandom, $urandom}, 32'($urandom), 2'(i)};
                        n++;
                    end
                end
            end
            src_len[i] = n;
            src_pos[i] = 0;
        end
        reset_dut();
        m_locked = 1'b0;
        m_owner  = 0;
        m_last   = NUM_PE - 1;
        m_err    = 1'b0;
        exp_q.delete();

        for (int cy = 0; cy < 4000; cy++) begin
            pending = exp_q.size();
            for (int i = 0; i < NUM_PE; i++) pending += src_len[i] - src_pos[i];
            if (pending == 0) break;
            sys_rdy = ($urandom % 4) != 0;
            for (int i = 0; i < NUM_PE; i++) begin
                pe_valid[i] = (src_pos[i] < src_len[i]) && (($urandom % 5) != 0);
                if (src_pos[i] < src_len[i]) nb = src_mem[i][src_pos[i]];
                else nb = {2'($urandom), 2'($urandom), {$urandom, $urandom}, 32'($urandom), 2'(i)};
                pe_cntl[i*2 +: 2]   = nb.cntl;
                pe_type[i*2 +: 2]   = nb.typ;
                pe_data[i*64 +: 64] = nb.data;
                pe_oob[i*32 +: 32]  = nb.oob;
            end
            @(negedge clk);
            g = -1;
            exp_rdy = '0;
            if (m_locked) g = m_owner;
            else begin
                for (int k = 1; k <= NUM_PE; k++) begin
                    cand = (m_last + k) % NUM_PE;
                    if (g < 0 && pe_valid[cand]) g = cand;
                end
            end
            if (g >= 0) exp_rdy[g] = (exp_q.size() < DEPTH);
            check("rnd_ready", 128'(pe_ready), 128'(exp_rdy));
            check("rnd_valid", 128'(o_valid), 128'(exp_q.size() != 0));
            if (exp_q.size() != 0) check("rnd_beat", 128'(out_b), 128'(exp_q[0]));
            check("rnd_perr", 128'(perr), 128'(PERR_EN & m_err));
            do_pop = (exp_q.size() != 0) && sys_rdy;
            acc    = (g >= 0) && exp_rdy[g] && pe_valid[g];
            if (acc) nb = src_mem[g][src_pos[g]];
            @(posedge clk);
            if (do_pop) void'(exp_q.pop_front());
            if (acc) begin
                src_pos[g]++;
                if (!m_locked) begin
                    m_last = g;
                    if (nb.cntl == SOM) begin
                        exp_q.push_back(nb);
                        m_locked = 1'b1;
                        m_owner  = g;
                    end else if (nb.cntl == SEOM) begin
                        exp_q.push_back(nb);
                    end else begin
                        m_err = 1'b1;
                    end
                end else begin
                    exp_q.push_back(nb);
                    if (nb.cntl == SOM) m_err = 1'b1;
                    if (nb.cntl == EOM || nb.cntl == SEOM) begin
                        if (nb.cntl == SEOM) m_err = 1'b1;
                        m_locked = 1'b0;
                        m_last   = m_owner;
                    end
                end
            end
            #1;
        end
        pending = exp_q.size();
        for (int i = 0; i < NUM_PE; i++) pending += src_len[i] - src_pos[i];
        check("rnd_drain", 128'(pending), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
